out_port_queue: RTL and testbench

Output-port buffer directly downstream of `out_FF`: watches the same `loadOut` strobe that enables the output flip-flops, captures the freshly registered nibble from `out_FF.Q` one cycle later, and queues it in a small FIFO. It presents queued nibbles to an external consumer over a valid/ready handshake, so a slow peripheral never misses a value the CPU writes with an OUT instruction. It has a single clock domain and no combinational path from `load_out` to any output.

---
 rtl/out_port_queue.sv | 87 ++++++++
 tb/tb_out_port_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/out_port_queue.sv
// Output-port FIFO fed by out_FF: captures ff_q one cycle after each load_out strobe
// and serves it over valid/ready. Optional sticky drop flag: OUTQ_OVERFLOW_FLAG_EN.
module out_port_queue #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_out,
  input  logic [WIDTH-1:0]         ff_q,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
  logic [AW:0]      count_nx;
  logic             load_d, push, pop, accept, drop;
  logic [WIDTH-1:0] head_nx;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    push      = load_d;
    pop       = out_valid && out_ready;
    accept    = push && (!full || pop);
    drop      = push && full && !pop;
    rd_ptr_nx = pop    ? rd_ptr + AW'(1) : rd_ptr;
    wr_ptr_nx = accept ? wr_ptr + AW'(1) : wr_ptr;
    count_nx  = count;
    case ({accept, pop})
      2'b10:   count_nx = count + (AW+1)'(1);
      2'b01:   count_nx = count - (AW+1)'(1);
      default: count_nx = count;
    endcase
    // The new head may be the entry being written this cycle (empty, or one entry being popped).
    head_nx = '0;
    if (count_nx != '0) begin
      if (accept && (rd_ptr_nx == wr_ptr)) head_nx = ff_q;
      else                                 head_nx = mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_d    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      load_d    <= load_out;
      rd_ptr    <= rd_ptr_nx;
      wr_ptr    <= wr_ptr_nx;
      count     <= count_nx;
      out_valid <= (count_nx != '0);
      out_data  <= head_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= ff_q;
  end

`ifdef OUTQ_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, drop};
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_queue.sv
// Bench for out_port_queue: directed vector table followed by randomized traffic
// checked against a queue-based reference model. out_FF is modelled in the bench.
module tb_out_port_queue;
  localparam int DEPTH = 4;
`ifdef OUTQ_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, load_out = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] bus = '0, ff_q = '0;
  logic       out_valid, full, empty, overflow;
  logic [3:0] out_data;
  logic [2:0] count;

  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  // out_FF: loads the bus on the edge that samples load_out
  always @(posedge clk) if (load_out) ff_q <= bus;

  out_port_queue #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_out(load_out), .ff_q(ff_q),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
    .out_data(out_data), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  typedef struct {
    bit r, l; logic [3:0] b; bit y, c;
    logic [3:0] d; int n; bit o;
  } vec_t;
  vec_t vecs[$];

  // reference model state
  logic [3:0] mq[$];
  bit         mpend = 1'b0, movf = 1'b0;
  logic [3:0] mff = '0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(bit r, bit l, logic [3:0] b, bit y, bit c, logic [3:0] d, int n, bit o);
    vec_t v;
    v.r = r; v.l = l; v.b = b; v.y = y; v.c = c; v.d = d; v.n = n; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic model_step(bit r, bit l, logic [3:0] b, bit y, bit c);
    bit popx, dropx;
    if (r) begin
      mq.delete(); mpend = 1'b0; movf = 1'b0;
    end else begin
      popx  = (mq.size() > 0) && y;
      dropx = 1'b0;
      if (popx) void'(mq.pop_front());
      if (mpend) begin
        if (mq.size() < DEPTH) mq.push_back(mff);
        else dropx = 1'b1;
      end
      if (OVF_EN) begin
        if (dropx) movf = 1'b1;
        else if (c) movf = 1'b0;
      end
      mpend = l;
    end
    if (l) mff = b;
  endtask

  task automatic cycle(bit r, bit l, logic [3:0] b, bit y, bit c);
    reset = r; load_out = l; bus = b; out_ready = y; ovf_clr = c;
    @(posedge clk);
    model_step(r, l, b, y, c);
    @(negedge clk);
  endtask

  task automatic check_outputs(string tag, logic [3:0] d, int n, bit o);
    check({tag, " valid"},    8'(out_valid), 8'(n != 0));
    check({tag, " data"},     8'(out_data),  8'(d));
    check({tag, " count"},    8'(count),     8'(n));
    check({tag, " full"},     8'(full),      8'(n == DEPTH));
    check({tag, " empty"},    8'(empty),     8'(n == 0));
    check({tag, " overflow"}, 8'(overflow),  8'(o));
  endtask

  initial begin
    //  r  l  bus    y  c   data   n  ovf   (expected after the edge)
    add(1, 0, 4'h0, 0, 0, 4'h0, 0, 0);  // reset
    add(0, 1, 4'h1, 0, 0, 4'h0, 0, 0);  // single pulse 0001
    add(0, 0, 4'h0, 0, 0, 4'h1, 1, 0);  // visible 2 edges after strobe
    for (int k = 0; k < 5; k++) add(0, 0, 4'h0, 0, 0, 4'h1, 1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);  // one pop -> empty
    add(0, 1, 4'h1, 0, 0, 4'h0, 0, 0);  // four pulses
    add(0, 1, 4'h2, 0, 0, 4'h1, 1, 0);
    add(0, 1, 4'h4, 0, 0, 4'h1, 2, 0);
    add(0, 1, 4'h8, 0, 0, 4'h1, 3, 0);
    add(0, 0, 4'h0, 0, 0, 4'h1, 4, 0);  // full
    add(0, 1, 4'hF, 0, 0, 4'h1, 4, 0);  // fifth pulse
    add(0, 0, 4'h0, 0, 0, 4'h1, 4, 1);  // dropped
    add(0, 0, 4'h0, 0, 1, 4'h1, 4, 0);  // ovf_clr
    add(0, 0, 4'h0, 1, 0, 4'h2, 3, 0);  // drain in order
    add(0, 0, 4'h0, 1, 0, 4'h4, 2, 0);
    add(0, 0, 4'h0, 1, 0, 4'h8, 1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
    add(0, 1, 4'h1, 0, 0, 4'h0, 0, 0);  // refill
    add(0, 1, 4'h2, 0, 0, 4'h1, 1, 0);
    add(0, 1, 4'h3, 0, 0, 4'h1, 2, 0);
    add(0, 1, 4'h4, 0, 0, 4'h1, 3, 0);
    add(0, 1, 4'hA, 0, 0, 4'h1, 4, 0);
    add(0, 0, 4'h0, 1, 0, 4'h2, 4, 0);  // push 1010 with pop while full
    add(0, 0, 4'h0, 1, 0, 4'h3, 3, 0);
    add(0, 0, 4'h0, 1, 0, 4'h4, 2, 0);
    add(0, 0, 4'h0, 1, 0, 4'hA, 1, 0);  // 1010 emerges fourth
    add(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
    add(0, 1, 4'h3, 0, 0, 4'h0, 0, 0);  // load_out held 3 cycles
    add(0, 1, 4'h5, 0, 0, 4'h3, 1, 0);
    add(0, 1, 4'h6, 0, 0, 4'h3, 2, 0);
    add(0, 0, 4'h0, 0, 0, 4'h3, 3, 0);
    add(0, 0, 4'h0, 1, 0, 4'h5, 2, 0);
    add(0, 0, 4'h0, 0, 0, 4'h5, 2, 0);  // 5 then 6 still queued
    add(1, 1, 4'h9, 0, 0, 4'h0, 0, 0);  // reset with 2 entries, strobe lost
    add(0, 0, 4'h0, 0, 0, 4'h0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].l, vecs[i].b, vecs[i].y, vecs[i].c);
      check_outputs($sformatf("row%0d", i), vecs[i].d, vecs[i].n, vecs[i].o & OVF_EN);
    end

    for (int i = 0; i < 3000; i++) begin
      int ready_pct;
      bit r, l, y, c;
      logic [3:0] b;
      ready_pct = (i / 300) % 3 == 0 ? 15 : ((i / 300) % 3 == 1 ? 50 : 90);
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 99) < 60);
      y = ($urandom_range(0, 99) < ready_pct);
      c = ($urandom_range(0, 99) < 8);
      b = 4'($urandom);
      cycle(r, l, b, y, c);
      check_outputs($sformatf("rnd%0d", i), (mq.size() > 0) ? mq[0] : 4'h0, mq.size(), movf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
